// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder: link widths,
// error-bit positions and the instruction value returned on an error.
package imem_responder_pkg;

  localparam int InstWidth    = 32;
  localparam int ImmWidth     = 64;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  localparam logic [InstWidth-1:0] ERR_INST = 32'h0000_0000;

  // Build the 2-bit error code from the two independent address checks.
  function automatic logic [1:0] pack_err(input logic misaligned, input logic out_of_range);
    logic [1:0] e;
    e = 2'b00;
    e[ERR_MISALIGN] = misaligned;
    e[ERR_RANGE]    = out_of_range;
    return e;
  endfunction

endpackage

// File: rtl/imem_responder_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Push and pop may happen in the same cycle, including while full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = store[rd_ptr_reg];

  // Storage is never reset; only the pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping, wrapping at DEPTH (need not be a power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_W'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, checks alignment/range,
// reads the word array in the accept cycle, delays the result to a fixed
// latency and queues responses in a FIFO that absorbs consumer backpressure.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                ADDR_W      = ImmWidth,
  parameter int                INST_W      = InstWidth,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(64'h8000_0000),
  parameter int                LATENCY     = 2,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_pc,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INST_W-1:0]              rsp_inst,
  output logic [1:0]                     rsp_err,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [INST_W-1:0]              wr_data,
  output logic                           busy
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam int                OUT_W = $clog2(FIFO_DEPTH + 1);
  localparam int                N_STG = LATENCY - 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH_WORDS) << 2;
  localparam logic [INST_W-1:0] ZERO_INST = INST_W'(ERR_INST);

  logic [INST_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        req_err;
  logic              accept;
  logic              rd_en;
  logic              fifo_push;
  logic [INST_W+1:0] fifo_push_data;
  logic [INST_W+1:0] fifo_head;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [OUT_W-1:0]  outstanding_reg;

  // Offset is only meaningful when req_pc >= BASE_ADDR; the range check covers the rest.
  assign offset  = req_pc - BASE_ADDR;
  assign idx     = offset[IDX_W+1:2];
  assign req_err = pack_err(|req_pc[1:0], (req_pc < BASE_ADDR) || (offset >= SPAN));

  // The fifo_full term is redundant with the counter but keeps an overflow impossible by construction.
  assign req_ready = !rst && (outstanding_reg < OUT_W'(FIFO_DEPTH)) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign rd_en     = accept && (req_err == 2'b00);

  // Preload port; ignored during reset, array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= wr_data;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign fifo_push      = accept;
      assign fifo_push_data = {req_err, rd_en ? mem[idx] : ZERO_INST};
    end else begin : g_staged
      logic [INST_W-1:0] rd_data_reg;
      logic              stg_valid [N_STG];
      logic [1:0]        stg_err   [N_STG];
      logic [INST_W-1:0] stg_inst  [N_STG];

      // Registered read in the accept cycle; a same-cycle write to the word yields old data.
      always_ff @(posedge clk) begin
        if (rd_en) rd_data_reg <= mem[idx];
      end

      for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
        logic       valid_reg;
        logic [1:0] err_reg;
        if (gi == 0) begin : g_head
          // First stage captures the request outcome alongside the memory read.
          always_ff @(posedge clk) begin
            if (rst) valid_reg <= 1'b0;
            else     valid_reg <= accept;
            err_reg <= req_err;
          end
          assign stg_inst[gi] = (err_reg != 2'b00) ? ZERO_INST : rd_data_reg;
        end else begin : g_tail
          logic [INST_W-1:0] inst_reg;
          // Plain delay stage to pad the path out to the configured latency.
          always_ff @(posedge clk) begin
            if (rst) valid_reg <= 1'b0;
            else     valid_reg <= stg_valid[gi-1];
            err_reg  <= stg_err[gi-1];
            inst_reg <= stg_inst[gi-1];
          end
          assign stg_inst[gi] = inst_reg;
        end
        assign stg_valid[gi] = valid_reg;
        assign stg_err[gi]   = err_reg;
      end

      assign fifo_push      = stg_valid[N_STG-1];
      assign fifo_push_data = {stg_err[N_STG-1], stg_inst[N_STG-1]};
    end
  endgenerate

  sync_fifo #(
    .WIDTH (INST_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Head is masked so the outputs read zero whenever nothing is valid (e.g. after reset).
  assign rsp_valid = !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign rsp_inst  = rsp_valid ? fifo_head[INST_W-1:0] : '0;
  assign rsp_err   = rsp_valid ? fifo_head[INST_W+1:INST_W] : 2'b00;
  assign busy      = (outstanding_reg != '0);

  // Outstanding = requests in the delay stages plus queued responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
    end else if (accept && !fifo_pop) begin
      outstanding_reg <= outstanding_reg + OUT_W'(1);
    end else if (fifo_pop && !accept) begin
      outstanding_reg <= outstanding_reg - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with default parameters (LATENCY 2, FIFO_DEPTH 4).
module tb_imem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [1:0]  rsp_err;
  logic        wr_en;
  logic [9:0]  wr_idx;
  logic [31:0] wr_data;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] words [4];

  imem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    $display("preload idx=%0d data=%h", idx, data);
  endtask

  task automatic issue(input logic [63:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for the next response; needs rsp_ready high so it pops.
  task automatic wait_rsp(output logic [31:0] inst, output logic [1:0] err, output bit got);
    got  = 1'b0;
    inst = '0;
    err  = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (rsp_valid) begin
        inst = rsp_inst;
        err  = rsp_err;
        got  = 1'b1;
        $display("rsp inst=%h err=%b", inst, err);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_pc    = BASE;
    rsp_ready = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold cycle %0d: req_ready=%b rsp_valid=%b, want 0 0", i, req_ready, rsp_valid);
      end
      tick();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 2'b00 || rsp_inst !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: busy=%b rsp_valid=%b err=%b inst=%h, want 0 0 00 0", busy, rsp_valid, rsp_err, rsp_inst);
    end
    $display("reset released");
  endtask

  task automatic test_streaming();
    logic exp_v;
    for (int i = 0; i < 4; i++) preload(10'(i), words[i]);
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req_valid = 1'b1;
        req_pc    = BASE + 64'(4 * c);
        compared++;
        if (req_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL stream_ready cycle %0d: req_ready=%b want 1", c, req_ready);
        end
      end else begin
        req_valid = 1'b0;
      end
      #1;
      exp_v = (c >= 2 && c < 6);
      compared++;
      if (rsp_valid !== exp_v) begin
        mismatched++;
        $display("FAIL stream_valid cycle %0d: rsp_valid=%b want %b", c, rsp_valid, exp_v);
      end
      if (exp_v) begin
        compared++;
        if (rsp_inst !== words[c-2] || rsp_err !== 2'b00) begin
          mismatched++;
          $display("FAIL stream_data cycle %0d: inst=%h err=%b want %h 00", c, rsp_inst, rsp_err, words[c-2]);
        end else begin
          $display("stream rsp cycle %0d inst=%h", c, rsp_inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int got;
    acc       = 0;
    got       = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      req_pc    = BASE + 64'(4 * acc);
      #1;
      if (req_ready) begin
        $display("bp accept pc=%h", req_pc);
        acc++;
      end
      tick();
    end
    req_valid = 1'b0;
    #1;
    compared++;
    if (acc !== 4) begin
      mismatched++;
      $display("FAIL bp_accepted: got %0d want 4", acc);
    end
    compared++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_stalled: req_ready=%b busy=%b want 0 1", req_ready, busy);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 1) begin
        compared++;
        if (req_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_ready_return: req_ready=%b want 1", req_ready);
        end
      end
      if (rsp_valid) begin
        if (got < 4) begin
          compared++;
          if (rsp_inst !== words[got] || rsp_err !== 2'b00) begin
            mismatched++;
            $display("FAIL bp_order %0d: inst=%h err=%b want %h 00", got, rsp_inst, rsp_err, words[got]);
          end else begin
            $display("bp rsp %0d inst=%h", got, rsp_inst);
          end
        end
        got++;
      end
      tick();
    end
    compared++;
    if (got !== 4) begin
      mismatched++;
      $display("FAIL bp_count: %0d responses want 4", got);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_busy_clear: busy=%b want 0", busy);
    end
  endtask

  task automatic test_errors();
    logic [63:0] pcs  [4];
    logic [1:0]  errs [4];
    logic [31:0] inst;
    logic [1:0]  err;
    bit          got;
    pcs[0] = 64'h8000_0002; errs[0] = 2'b01;
    pcs[1] = 64'h7FFF_FFFC; errs[1] = 2'b10;
    pcs[2] = 64'h8000_1000; errs[2] = 2'b10;
    pcs[3] = 64'h8000_1001; errs[3] = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(pcs[i]);
      wait_rsp(inst, err, got);
      compared++;
      if (!got || err !== errs[i] || inst !== 32'h0) begin
        mismatched++;
        $display("FAIL err_pc_%h: got=%0d err=%b inst=%h want err=%b inst=0", pcs[i], got, err, inst, errs[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] inst;
    logic [1:0]  err;
    bit          got;
    rsp_ready = 1'b1;
    preload(10'd5, 32'hAAAA_AAAA);
    wr_en     = 1'b1;
    wr_idx    = 10'd5;
    wr_data   = 32'h5555_5555;
    req_valid = 1'b1;
    req_pc    = 64'h8000_0014;
    tick();
    wr_en     = 1'b0;
    req_valid = 1'b0;
    wait_rsp(inst, err, got);
    compared++;
    if (!got || inst !== 32'hAAAA_AAAA || err !== 2'b00) begin
      mismatched++;
      $display("FAIL collision_old: got=%0d inst=%h err=%b want AAAAAAAA 00", got, inst, err);
    end
    issue(64'h8000_0014);
    wait_rsp(inst, err, got);
    compared++;
    if (!got || inst !== 32'h5555_5555 || err !== 2'b00) begin
      mismatched++;
      $display("FAIL collision_new: got=%0d inst=%h err=%b want 55555555 00", got, inst, err);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] inst;
    logic [1:0]  err;
    bit          got;
    bit          seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(BASE + 64'(4 * i));
    #1;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_busy_before: busy=%b want 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_cleared: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
    end
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_dropped: stale response seen=%b want 0", seen);
    end
    issue(BASE + 64'd8);
    wait_rsp(inst, err, got);
    compared++;
    if (!got || inst !== 32'h0030_0193 || err !== 2'b00) begin
      mismatched++;
      $display("FAIL midrst_preserved: got=%0d inst=%h err=%b want 00300193 00", got, inst, err);
    end
  endtask

  initial begin
    words[0] = 32'h0010_0093;
    words[1] = 32'h0020_0113;
    words[2] = 32'h0030_0193;
    words[3] = 32'h0040_0213;
    test_reset();
    test_streaming();
    test_backpressure();
    test_errors();
    test_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
